seq_mult_start_gen: RTL and testbench
=====================================

Name: seq_mult_start_gen

Overview:
- Upstream front end for the 4x4 sequential multiplier stage that drives the DLA output.
- Takes the raw external 200 kHz square wave `x` and synchronizes it into the `clk` domain.
- Glitch-filters it and detects both edges.
- For each accepted edge, issues a one-cycle `start` with latched operands, then waits for the multiplier's `done` before accepting another edge.
- Replaces the permanently-asserted start with a controlled, edge-driven handshake.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `x` synchronizer chain (min 2).
- STABLE_CYCLES, 4, consecutive synchronized samples that must disagree with the filtered level before it updates (min 1).
- WIDTH, 4, operand width of `a` and `b`.
- TIMEOUT, 63, max cycles spent in WAIT for `done` before abort (min 1).

Ports:
- clk  input  1  system clock.
- clr  input  1  synchronous, active-low reset.
- x  input  1  asynchronous external square wave.
- done  input  1  one-cycle pulse from the multiplier when the product is valid.
- start  output  1  one-cycle pulse to the multiplier.
- a  output  WIDTH  multiplicand; held stable from `start` until `done`.
- b  output  WIDTH  multiplier; held stable from `start` until `done`.
- busy  output  1  high in ISSUE and WAIT.
- overrun  output  1  sticky; an edge was dropped while busy.
- timeout  output  1  sticky; WAIT aborted without `done`.
- edge_count  output  8  count of accepted edges, wraps 255->0.

Behaviour:
- Reset: reset is synchronous and active-low on `clr`, sampled on rising `clk`. When clr=0 at a rising edge, the following all clear:
  - synchronizer chain, filtered level `filt`, filter counter;
  - state=IDLE, start=0, a=0, b=0, busy=0, overrun=0, timeout=0, edge_count=0.
- Reset mid-operation (ISSUE/WAIT) abandons the transaction. No `start` is emitted in the cycle after reset.
- Synchronizer: `x_sync` is `x` delayed by SYNC_STAGES flops.
- Filter:
  - Counter increments each cycle x_sync != filt and clears whenever x_sync == filt.
  - When the counter would reach STABLE_CYCLES, `filt` toggles and the counter clears.
  - Pulses shorter than STABLE_CYCLES cycles are ignored.
- Edge pulse: `edge` = filt changed this cycle (both rising and falling), one cycle wide.
- FSM, states IDLE, ISSUE, WAIT:
  - IDLE:
    - On `edge`: latch a = {WIDTH{new filt}}, b = {WIDTH{1'b1}}, edge_count += 1, go ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: start=1 for exactly this cycle, clear the wait counter, go WAIT.
  - WAIT: the wait counter increments each cycle.
    - On `done`: go IDLE.
    - On `done` and `edge` in the same cycle: treat as IDLE+edge, i.e. latch the new operands, count the edge, go ISSUE. No overrun.
    - On `edge` without `done`: set `overrun`; the edge is dropped, not queued, and edge_count is not incremented.
    - If the counter reaches TIMEOUT with no `done`: set `timeout`, go IDLE.
  - `done` in IDLE or ISSUE is ignored.
- Latency: `start` is high in cycle SYNC_STAGES+STABLE_CYCLES+1 after the first rising `clk` that samples the new `x` level (7 with defaults).
- a/b change only on entry to ISSUE.
- Sticky flags clear only on reset.
- edge_count wraps modulo 256 with no flag.

Test Plan:
- Reset: hold clr=0 for 3 cycles with x toggling -> all outputs 0. Release with x=0 steady -> no `start` for 20 cycles.
- Rising edge, defaults: x 0->1, done returned 5 cycles after start -> start pulses once at cycle 7, a=4'hF, b=4'hF, busy high 6 cycles, edge_count=1. The later falling edge gives a=4'h0, edge_count=2.
- Glitch: x high for 3 cycles then low -> no `start`, edge_count unchanged. High for 4 cycles -> `start` issued.
- Overrun: rising edge accepted, done withheld, falling edge filtered while in WAIT -> overrun=1, edge_count=1, a stays 4'hF. Then done -> IDLE.
- Coincidence: done asserted on the same cycle as a filtered edge in WAIT -> next cycle start=1 with new operands, overrun=0.
- Timeout + wrap:
  - done never returned -> timeout=1 exactly TIMEOUT cycles after WAIT entry, busy=0 after.
  - 256 accepted edges -> edge_count returns to 0.

Source files
------------

// File: rtl/seq_mult_start_gen.sv
// seq_mult_start_gen
//   Front end for the 4x4 sequential multiplier. It synchronizes the external
//   square wave x into clk, glitch-filters it and detects both edges. Each
//   accepted edge issues a one-cycle start with latched operands. Further
//   edges are refused until the multiplier returns done or the wait times out.
//
// Ports
//   clk        system clock
//   clr        synchronous active-low reset
//   x          asynchronous external square wave
//   done       one-cycle product-valid pulse from the multiplier
//   start      one-cycle pulse to the multiplier
//   a, b       operands, held from start until done
//   busy       high while a transaction is outstanding (ISSUE/WAIT)
//   overrun    sticky: an edge arrived while busy and was dropped
//   timeout    sticky: WAIT gave up without seeing done
//   edge_count accepted edges, modulo 256
module seq_mult_start_gen #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int WIDTH         = 4,
    parameter int TIMEOUT       = 63
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             x,
    input  logic             done,
    output logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             overrun,
    output logic             timeout,
    output logic [7:0]       edge_count
);

    localparam int FW = $clog2(STABLE_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   x_sync;
    logic                   filt, filt_q, edge_pulse;
    logic [FW-1:0]          fcnt;
    logic [WW-1:0]          wcnt;
    state_t                 state, state_nxt;
    logic                   accept, drop, abort;

    // Synchronizer chain; x_sync is the oldest sample.
    always_ff @(posedge clk) begin
        if (!clr) sync <= '0;
        else      sync <= {sync[SYNC_STAGES-2:0], x};
    end
    assign x_sync = sync[SYNC_STAGES-1];

    // Glitch filter: filt only follows x_sync after STABLE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (!clr) begin
            filt   <= 1'b0;
            filt_q <= 1'b0;
            fcnt   <= '0;
        end else begin
            filt_q <= filt;
            if (x_sync == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(STABLE_CYCLES - 1)) begin
                filt <= ~filt;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // One-cycle pulse on either direction of filt.
    assign edge_pulse = filt ^ filt_q;

    always_ff @(posedge clk) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (edge_pulse) accept = 1'b1;
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
                drop      = edge_pulse;
            end
            S_WAIT: begin
                // done in the same cycle as an edge frees the slot for it
                if (done) begin
                    if (edge_pulse) accept = 1'b1;
                    else            state_nxt = S_IDLE;
                end else begin
                    drop = edge_pulse;
                    if (wcnt == WW'(TIMEOUT - 1)) begin
                        abort     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (accept) state_nxt = S_ISSUE;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            wcnt       <= '0;
            a          <= '0;
            b          <= '0;
            edge_count <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (state == S_ISSUE)     wcnt <= '0;
            else if (state == S_WAIT) wcnt <= wcnt + WW'(1);
            if (accept) begin
                a          <= {WIDTH{filt}};
                b          <= '1;
                edge_count <= edge_count + 8'd1;
            end
            if (drop)  overrun <= 1'b1;
            if (abort) timeout <= 1'b1;
        end
    end

    assign start = (state == S_ISSUE);
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_seq_mult_start_gen.sv
module tb_seq_mult_start_gen;

    localparam int SYNC = 2;
    localparam int STAB = 4;
    localparam int W    = 4;
    localparam int TO   = 63;

    logic         clk = 1'b0;
    logic         clr, x, done;
    logic         start, busy, overrun, timeout;
    logic [W-1:0] a, b;
    logic [7:0]   edge_count;

    int checks = 0;
    int errors = 0;

    // run() statistics
    int r_starts, r_busy, r_first, r_ec, cd;
    logic [W-1:0] r_a, r_b;

    seq_mult_start_gen #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr), .x(x), .done(done), .start(start), .a(a), .b(b),
        .busy(busy), .overrun(overrun), .timeout(timeout), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        r_starts = 0; r_busy = 0; r_first = -1; r_ec = -1; r_a = 'x; r_b = 'x;
    endtask

    task automatic do_reset();
        clr = 1'b0; x = 1'b0; done = 1'b0; cd = 0;
        step(); step();
        clr = 1'b1;
        clr_stats();
    endtask

    // Runs n cycles; answers each start with a done pulse dly cycles later
    // (dly < 0: never answer).
    task automatic run(input int n, input int dly);
        for (int i = 0; i < n; i++) begin
            step();
            done = 1'b0;
            if (busy) r_busy++;
            if (start) begin
                r_starts++;
                r_a = a; r_b = b; r_ec = edge_count;
                if (r_first < 0) r_first = i + 1;
                cd = dly;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = i[0];
            step();
        end
        checks++;
        if ({start, busy, overrun, timeout, a, b, edge_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b busy=%b ovr=%b to=%b a=%h b=%h ec=%0d, need all 0",
                     start, busy, overrun, timeout, a, b, edge_count);
        end
        clr = 1'b1; x = 1'b0; cd = 0;
        clr_stats();
        run(20, 1);
        checks++;
        if (r_starts !== 0 || edge_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_quiet: starts=%0d ec=%0d, need 0 and 0", r_starts, edge_count);
        end
    endtask

    task automatic test_rising();
        do_reset();
        run(5, 5);
        x = 1'b1;
        clr_stats();
        run(30, 5);
        checks++;
        if (r_starts !== 1 || r_first !== 7) begin
            errors++;
            $display("FAIL rise_latency: starts=%0d first=%0d, need 1 at 7", r_starts, r_first);
        end
        checks++;
        if (r_a !== 4'hF || r_b !== 4'hF || r_ec !== 1) begin
            errors++;
            $display("FAIL rise_operands: a=%h b=%h ec=%0d, need F F 1", r_a, r_b, r_ec);
        end
        checks++;
        if (r_busy !== 6) begin
            errors++;
            $display("FAIL rise_busy: busy cycles=%0d, need 6", r_busy);
        end
        x = 1'b0;
        clr_stats();
        run(30, 5);
        checks++;
        if (r_starts !== 1 || r_first !== 7 || r_a !== 4'h0 || r_b !== 4'hF || r_ec !== 2) begin
            errors++;
            $display("FAIL fall_operands: starts=%0d first=%0d a=%h b=%h ec=%0d, need 1 7 0 F 2",
                     r_starts, r_first, r_a, r_b, r_ec);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        x = 1'b1;
        run(3, 1);
        x = 1'b0;
        run(20, 1);
        checks++;
        if (r_starts !== 0 || edge_count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_short: starts=%0d ec=%0d, need 0 0", r_starts, edge_count);
        end
        x = 1'b1;
        run(4, 1);
        x = 1'b0;
        run(25, 1);
        checks++;
        if (r_starts !== 2 || edge_count !== 8'd2 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL glitch_min: starts=%0d ec=%0d ovr=%b, need 2 2 0", r_starts, edge_count, overrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        x = 1'b1;
        run(10, -1);
        x = 1'b0;
        run(15, -1);
        checks++;
        if (overrun !== 1'b1 || edge_count !== 8'd1 || a !== 4'hF || busy !== 1'b1 || r_starts !== 1) begin
            errors++;
            $display("FAIL overrun: ovr=%b ec=%0d a=%h busy=%b starts=%0d, need 1 1 F 1 1",
                     overrun, edge_count, a, busy, r_starts);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_done: busy=%b, need 0", busy);
        end
        step();
        checks++;
        if (start !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_dropped: start=%b ovr=%b, need 0 1", start, overrun);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        x = 1'b1;
        run(10, -1);
        x = 1'b0;
        repeat (6) step();
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (start !== 1'b1 || a !== 4'h0 || overrun !== 1'b0 || edge_count !== 8'd2) begin
            errors++;
            $display("FAIL coincide: start=%b a=%h ovr=%b ec=%0d, need 1 0 0 2", start, a, overrun, edge_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        x = 1'b1;
        run(7, -1);
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL to_start: start=%b, need 1", start);
        end
        repeat (TO) step();
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early: to=%b busy=%b, need 0 1", timeout, busy);
        end
        step();
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_fire: to=%b busy=%b, need 1 0", timeout, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            x = ~x;
            run(12, 1);
        end
        run(15, 1);
        checks++;
        if (r_starts !== 256 || edge_count !== 8'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL wrap: starts=%0d ec=%0d ovr=%b, need 256 0 0", r_starts, edge_count, overrun);
        end
    endtask

    // Random x and done against a model built from the block's rules.
    task automatic test_random();
        int xd[SYNC];
        int run_len, waited, phase, xhold, ec;
        logic m_filt, m_tog, e, xs, xi, di, ov, to;
        logic [W-1:0] ma, mb;
        logic [W+W+12-1:0] exp_v, act_v;
        do_reset();
        foreach (xd[i]) xd[i] = 0;
        run_len = 0; waited = 0; phase = 0; ec = 0;
        m_filt = 0; m_tog = 0; ov = 0; to = 0; ma = '0; mb = '0;
        xhold = $urandom_range(1, 12);
        for (int c = 0; c < 4000; c++) begin
            xi = x; di = done;
            step();
            e = m_tog;
            // transaction phase: 0 idle, 1 issued, 2 waiting for done
            if (phase == 0 && e) phase = 3;
            else if (phase == 1) begin
                if (e) ov = 1;
                phase = 2; waited = 0;
            end else if (phase == 2) begin
                if (di) phase = e ? 3 : 0;
                else begin
                    if (e) ov = 1;
                    waited++;
                    if (waited == TO) begin to = 1; phase = 0; end
                end
            end
            if (phase == 3) begin
                ma = {W{m_filt}}; mb = '1; ec = (ec + 1) % 256; phase = 1;
            end
            xs = xd[SYNC-1][0];
            for (int i = SYNC - 1; i > 0; i--) xd[i] = xd[i-1];
            xd[0] = xi;
            m_tog = 0;
            if (xs != m_filt) begin
                run_len++;
                if (run_len == STAB) begin m_filt = ~m_filt; run_len = 0; m_tog = 1; end
            end else run_len = 0;
            exp_v = {phase == 1, phase != 0, ma, mb, ec[7:0], ov, to};
            act_v = {start, busy, a, b, edge_count, overrun, timeout};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random c=%0d: {start,busy,a,b,ec,ovr,to}=%h, need %h", c, act_v, exp_v);
            end
            xhold--;
            if (xhold == 0) begin
                x = ~x;
                xhold = $urandom_range(1, 12);
            end
            done = 1'b0;
            if (start) cd = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(1, 8);
            else if (cd > 0) begin
                cd--;
                if (cd == 0) done = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) done = 1'b1;
        end
    endtask

    initial begin
        clr = 1'b0; x = 1'b0; done = 1'b0; cd = 0;
        clr_stats();
        test_reset();
        test_rising();
        test_glitch();
        test_overrun();
        test_coincide();
        test_timeout();
        test_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
